alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 8-bit combinational ALU, sitting between the control unit and the accumulator/data bus.
- Adds a valid/ready handshake on input and output, a persistent flag register (Z, C, N, V), and carry-chained ops (ADC/SBC) for multi-word arithmetic.
- Adds shift ops and an optional iterative multiply.
- Operand width is a parameter; the default reproduces the 8-bit datapath.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_shift.sv | 52 +++++
 rtl/alu_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, flag layout and FSM state codes.
// Used by alu_seq and alu_mul_shift.
package alu_pkg;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBC = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Field order gives bit positions {V,N,C,Z} = [3:0], matching the FLG_* indices.
  typedef struct packed {
    logic v;
    logic n;
    logic c;
    logic z;
  } flags_t;

endpackage

// File: rtl/alu_mul_shift.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle over WIDTH cycles.
// product is the value the accumulator takes on the next edge, so it is final while done is high.
module alu_mul_shift
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;

  // Upper half accumulates the partial sums; lower half holds the multiplier bits still to consume.
  assign addend   = acc_q[0] ? mcand_q : '0;
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_next = {sum, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (start) begin
      mcand_q <= a;
      acc_q   <= {{WIDTH{1'b0}}, b};
      count_q <= CNT_INIT;
    end else if (count_q != '0) begin
      acc_q   <= acc_next;
      count_q <= count_q - CNT_ONE;
    end
  end

  assign busy    = (count_q != '0);
  assign done    = (count_q == CNT_ONE);
  assign product = acc_next;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, persistent {V,N,C,Z} flags and carry-chained ADC/SBC.
// Define ALU_MUL_EN to build the iterative multiplier for op 12; otherwise op 12 reports err.
module alu_seq
  import alu_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic [1:0]         state_q;
  logic [WIDTH-1:0]   result_q;
  flags_t             flg_q;
  logic               err_q;

  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   opnd;
  logic               carry_in;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH-1:0]   alu_res;
  flags_t             alu_flg;
  logic               alu_err;
  flags_t             mul_flg;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && (alu_op == OP_MUL);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flg_q;
  assign err       = err_q;

  // INC/DEC reuse the add/sub paths with a constant 1; ADC/SBC chain in the stored carry.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    opnd     = b;
    carry_in = 1'b0;
    if ((alu_op == OP_INC) || (alu_op == OP_DEC)) begin
      opnd = {{(WIDTH-1){1'b0}}, 1'b1};
    end
    if ((alu_op == OP_ADC) || (alu_op == OP_SBC)) begin
      carry_in = flg_q.c;
    end
  end

  assign add_ext = {1'b0, a} + {1'b0, opnd} + {{WIDTH{1'b0}}, carry_in};
  assign sub_ext = {1'b0, a} - {1'b0, opnd} - {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    alu_res = '0;
    alu_flg = '0;
    alu_err = 1'b0;
    case (alu_op)
      OP_NOT: alu_res = ~a;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_ADD, OP_ADC, OP_INC: begin
        alu_res   = add_ext[MSB:0];
        alu_flg.c = add_ext[WIDTH];
        alu_flg.v = (a[MSB] == opnd[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBC, OP_DEC: begin
        // Bit WIDTH of the extended difference is the borrow out.
        alu_res   = sub_ext[MSB:0];
        alu_flg.c = sub_ext[WIDTH];
        alu_flg.v = (a[MSB] != opnd[MSB]) && (sub_ext[MSB] != a[MSB]);
      end
      OP_SHL: begin
        alu_res   = {a[MSB-1:0], 1'b0};
        alu_flg.c = a[MSB];
      end
      OP_SHR: begin
        alu_res   = {1'b0, a[MSB:1]};
        alu_flg.c = a[0];
      end
      default: alu_err = 1'b1;
    endcase
    // An illegal op leaves alu_res at zero, which yields exactly flags {0,0,0,1}.
    alu_flg.z = (alu_res == '0);
    alu_flg.n = alu_res[MSB];
  end

  always_comb begin
    mul_flg   = '0;
    mul_flg.c = (mul_product[2*WIDTH-1:WIDTH] != '0);
    mul_flg.z = (mul_product[MSB:0] == '0);
    mul_flg.n = mul_product[MSB];
  end

`ifdef ALU_MUL_EN
  logic mul_busy;

  alu_mul_shift #(
    .WIDTH   (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // The FSM and the multiplier count must leave BUSY on the same edge.
  assert property (@(posedge clk) disable iff (rst) (state_q == ST_BUSY) |-> mul_busy);
`else
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Result, flags and err change only on entry into DONE, so they stay stable while the consumer stalls.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flg_q    <= FLAGS_RST;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        state_q <= ST_BUSY;
      end else begin
        state_q  <= ST_DONE;
        result_q <= alu_res;
        flg_q    <= alu_flg;
        err_q    <= alu_err;
      end
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (mul_done) begin
            state_q  <= ST_DONE;
            result_q <= mul_product[MSB:0];
            flg_q    <= mul_flg;
            err_q    <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: table-driven vectors through a scoreboard plus hand-written
// sequences for latency, backpressure and reset corners. Follows ALU_MUL_EN for op 12 expectations.
module tb_alu_seq;
  import alu_pkg::*;

  localparam logic [3:0] TB_FLAGS_RST = 4'b0110;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    logic       err;
    int         id;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] alu_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       err;

  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[26];

  alu_seq #(
    .WIDTH     (8),
    .FLAGS_RST (TB_FLAGS_RST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                              input logic [7:0] res, input logic [3:0] flg, input logic e);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = res; v.flg = flg; v.err = e;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input vec_t v, input int id);
    exp_t e;
    bit   acc;
    int   n;
    e.res = v.res; e.flg = v.flg; e.err = v.err; e.id = id;
    alu_op   = v.op;
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
    sb.push_back(e);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    check($sformatf("v%0d accepted", id), acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", sb.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " out_valid"}, out_valid, 1'b0);
    check({tag, " in_ready"},  in_ready,  1'b1);
    check({tag, " result"},    result,    8'h00);
    check({tag, " err"},       err,       1'b0);
    check({tag, " flags"},     flags,     TB_FLAGS_RST);
  endtask

  // Asserts rst for one edge, checks the reset state, then releases it on the negedge.
  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_values(tag);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("output expected by scoreboard", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check($sformatf("v%0d result", mon_e.id), result, mon_e.res);
        check($sformatf("v%0d flags", mon_e.id),  flags,  mon_e.flg);
        check($sformatf("v%0d err", mon_e.id),    err,    mon_e.err);
      end
    end
  end

  initial begin
    int   lat;
    int   seen;
    vec_t v;

    checks = 0;
    errors = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_op = '0; out_ready = 1'b1;

    tbl[0]  = mk(OP_ADD, 8'hF0, 8'h20, 8'h10, 4'b0010, 1'b0);
    tbl[1]  = mk(OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000, 1'b0);
    tbl[2]  = mk(OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1000, 1'b0);
    tbl[3]  = mk(OP_SBC, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0);
    tbl[4]  = mk(OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b0100, 1'b0);
    tbl[5]  = mk(OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0);
    tbl[6]  = mk(OP_OR,  8'h0F, 8'h30, 8'h3F, 4'b0000, 1'b0);
    tbl[7]  = mk(OP_INC, 8'h7F, 8'h00, 8'h80, 4'b1100, 1'b0);
    tbl[8]  = mk(OP_DEC, 8'h00, 8'h00, 8'hFF, 4'b0110, 1'b0);
    tbl[9]  = mk(OP_SBC, 8'h05, 8'h02, 8'h02, 4'b0000, 1'b0);
    tbl[10] = mk(OP_SHL, 8'h81, 8'h00, 8'h02, 4'b0010, 1'b0);
    tbl[11] = mk(OP_ADC, 8'h7F, 8'h00, 8'h80, 4'b1100, 1'b0);
    tbl[12] = mk(OP_SHR, 8'h81, 8'h00, 8'h40, 4'b0010, 1'b0);
    tbl[13] = mk(OP_SUB, 8'h01, 8'h02, 8'hFF, 4'b0110, 1'b0);
    tbl[14] = mk(OP_DEC, 8'h80, 8'h00, 8'h7F, 4'b1000, 1'b0);
    tbl[15] = mk(4'hE,   8'h12, 8'h34, 8'h00, 4'b0001, 1'b1);
    tbl[16] = mk(OP_ADC, 8'hFF, 8'hFF, 8'hFE, 4'b0110, 1'b0);
    tbl[17] = mk(4'hF,   8'hAA, 8'h55, 8'h00, 4'b0001, 1'b1);
    tbl[18] = mk(OP_SBC, 8'h00, 8'h01, 8'hFF, 4'b0110, 1'b0);
    tbl[19] = mk(OP_SBC, 8'h10, 8'h0F, 8'h00, 4'b0001, 1'b0);
`ifdef ALU_MUL_EN
    tbl[20] = mk(OP_MUL, 8'h03, 8'h05, 8'h0F, 4'b0000, 1'b0);
`else
    tbl[20] = mk(OP_MUL, 8'h03, 8'h05, 8'h00, 4'b0001, 1'b1);
`endif
    tbl[21] = mk(OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100, 1'b0);
    tbl[22] = mk(OP_XOR, 8'h3C, 8'h3C, 8'h00, 4'b0001, 1'b0);
    tbl[23] = mk(OP_SHR, 8'h01, 8'h00, 8'h00, 4'b0011, 1'b0);
    tbl[24] = mk(OP_SHL, 8'h7F, 8'h00, 8'hFE, 4'b0100, 1'b0);
`ifdef ALU_MUL_EN
    tbl[25] = mk(OP_MUL, 8'hFF, 8'hFF, 8'h01, 4'b0010, 1'b0);
`else
    tbl[25] = mk(OP_MUL, 8'hFF, 8'hFF, 8'h00, 4'b0001, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // First op after reset: single-cycle latency.
    @(posedge clk); #1;
    send(mk(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011, 1'b0), 100);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check("add latency", lat, 1);
    drain();

    // Table vectors, issued back to back with the consumer always ready.
    @(posedge clk); #1;
    foreach (tbl[i]) send(tbl[i], i);
    drain();

    // Backpressure: result held while stalled, illegal op presented but not taken.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(mk(OP_XOR, 8'hAA, 8'h55, 8'hFF, 4'b0100, 1'b0), 200);
    alu_op = 4'hE; a = 8'h00; b = 8'h00; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d out_valid", k), out_valid, 1'b1);
      check($sformatf("stall%0d result", k),    result,    8'hFF);
      check($sformatf("stall%0d in_ready", k),  in_ready,  1'b0);
      check($sformatf("stall%0d err", k),       err,       1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(mk(OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b0), 201);
    @(negedge clk);
    check("back-to-back out_valid", out_valid, 1'b1);
    drain();

    // Multiply latency (or single-cycle illegal when compiled out).
    @(posedge clk); #1;
`ifdef ALU_MUL_EN
    send(mk(OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0011, 1'b0), 300);
`else
    send(mk(OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0001, 1'b1), 300);
`endif
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
`ifdef ALU_MUL_EN
    check("mul latency", lat, 9);
`else
    check("mul latency", lat, 1);
`endif
    drain();

    // Reset while holding a result in DONE.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(mk(OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000, 1'b0), 400);
    @(negedge clk);
    check("pre-reset out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    reset_pulse("reset in done");

`ifdef ALU_MUL_EN
    // Reset in the third cycle of a multiply.
    @(posedge clk); #1;
    send(mk(OP_MUL, 8'h07, 8'h03, 8'h15, 4'b0000, 1'b0), 500);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid-busy out_valid", out_valid, 1'b0);
    check("mid-busy in_ready", in_ready, 1'b0);
    reset_pulse("reset in busy");
`endif

    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no output after abort", seen, 0);

    // ADC right after reset takes its carry from FLAGS_RST.
    @(posedge clk); #1;
    v = mk(OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000, 1'b0);
    send(v, 600);
    send(mk(OP_SBC, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0), 601);
    send(mk(4'hE, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b1), 602);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
